// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: segment bit positions and the
// active-high hex glyph table (bit 0 = segment a .. bit 6 = segment g).
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry v is the glyph for hex value v (index 15 sits in the MSBs).
  localparam logic [15:0][6:0] SEG7_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic logic [6:0] seg7_glyph(input logic [3:0] v);
    return SEG7_GLYPHS[v];
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Datapath-side bundle of the scanner: display values in, pin levels out.
interface seg7_scan_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] digits_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic [N_DIGITS-1:0]   en_i;
  logic                  lz_sup_i;
  logic [6:0]            seg_o;
  logic                  dp_o;
  logic [N_DIGITS-1:0]   ds_o;
  logic                  frame_tick;

  // The driving side (datapath / bench) supplies values and observes pins.
  modport master (
    output digits_i, dp_i, en_i, lz_sup_i,
    input  seg_o, dp_o, ds_o, frame_tick
  );

  // The scanner itself.
  modport slave (
    input  digits_i, dp_i, en_i, lz_sup_i,
    output seg_o, dp_o, ds_o, frame_tick
  );
endinterface

// File: rtl/seg7_hex_dec.sv
// Combinational hex -> active-high 7-segment decode.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  assign seg = seg7_glyph(val);
endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed N-digit 7-segment scanner. A prescaler steps through one
// slot per digit; the whole input set is snapshotted once per frame so the
// visible frame never mixes old and new values.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 16,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  seg7_scan_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          wrap, last;

  logic [N_DIGITS-1:0][3:0] dig_s;
  logic [N_DIGITS-1:0]      dp_s, en_s;
  logic                     lz_s;

  logic [N_DIGITS-1:0][6:0] glyph;
  logic [N_DIGITS-1:0]      blank;
  logic [N_DIGITS-1:0]      ds_n;
  logic [6:0]               seg_n;
  logic                     slot_lit;

  assign wrap = (cnt == CW'(SCAN_DIV - 1));
  assign last = (idx == IW'(N_DIGITS - 1));

  // Slot prescaler and digit index; idx advances on every slot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame snapshot, loaded on the final cycle of the last slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_s <= '0;
      dp_s  <= '0;
      en_s  <= '0;
      lz_s  <= 1'b0;
    end else if (wrap && last) begin
      dig_s <= bus.digits_i;
      dp_s  <= bus.dp_i;
      en_s  <= bus.en_i;
      lz_s  <= bus.lz_sup_i;
    end
  end

  // One decoder per digit; the slot mux picks the active glyph.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dec
    seg7_hex_dec u_dec (
      .val (dig_s[k]),
      .seg (glyph[k])
    );
  end

  // Leading-zero mask: walk down from the top digit while every digit seen
  // so far is zero or dark; digit 0 always stays visible.
  always_comb begin
    logic run;
    blank = '0;
    run   = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      blank[k] = lz_s && run && (dig_s[k] == 4'h0) && (k != 0);
      run      = run && ((dig_s[k] == 4'h0) || !en_s[k]);
    end
  end

  // Blanking gap at the start of each slot against ghosting.
  if (BLANK_CYC == 0) begin : g_noblank
    assign slot_lit = 1'b1;
  end else begin : g_blank
    assign slot_lit = (cnt >= CW'(BLANK_CYC));
  end

  // Logical (active-high) digit select and segment pattern for this slot.
  always_comb begin
    ds_n      = '0;
    ds_n[idx] = en_s[idx] && slot_lit;
    seg_n     = blank[idx] ? 7'h00 : glyph[idx];
  end

  // Registered pin drivers; polarity only flips the pin level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ds_o       <= {N_DIGITS{DIG_ACT_LOW}};
      bus.seg_o      <= {7{SEG_ACT_LOW}};
      bus.dp_o       <= SEG_ACT_LOW;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.ds_o       <= ds_n ^ {N_DIGITS{DIG_ACT_LOW}};
      bus.seg_o      <= seg_n ^ {7{SEG_ACT_LOW}};
      bus.dp_o       <= dp_s[idx] ^ SEG_ACT_LOW;
      bus.frame_tick <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: 4 digits, 4-cycle slots, 1-cycle blanking,
// active-low pins. Every frame is checked cycle by cycle against expected
// ds/seg/dp patterns written out by hand.
module tb_seg7_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  seg7_scan_if #(.N_DIGITS(4)) bus ();

  seg7_scan #(
    .N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1),
    .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected active-low digit selects for frame cycle i (slot i/4, cnt i%4).
  function automatic logic [3:0] ds_exp(input int i, input logic [3:0] en);
    int s, c;
    s = i / 4;
    c = i % 4;
    if (c == 0 || !en[s]) return 4'hF;
    return ~(4'b0001 << s);
  endfunction

  // Advance to the next frame_tick, bounded.
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.frame_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL tick_wait: frame_tick=%b after %0d cycles, required 1", bus.frame_tick, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.digits_i = 16'h3210; bus.dp_i = 4'h0; bus.en_i = 4'hF; bus.lz_sup_i = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (bus.ds_o !== 4'b1111 || bus.seg_o !== 7'h7F || bus.dp_o !== 1'b1 || bus.frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ds=%b seg=%h dp=%b tick=%b, required 1111 7f 1 0",
               bus.ds_o, bus.seg_o, bus.dp_o, bus.frame_tick);
    end
    rst_n = 1'b1;
    wait_tick();
    // First frame runs on the cleared snapshot: all digits dark.
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.ds_o !== 4'b1111) begin
        bad++;
        $display("FAIL reset_dark_frame: cycle %0d ds=%b, required 1111", i, bus.ds_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_scan();
    logic [6:0] se [4];
    se = '{7'h40, 7'h79, 7'h24, 7'h30};   // ~glyph 0,1,2,3
    bus.digits_i = 16'h3210; bus.en_i = 4'hF; bus.dp_i = 4'h0; bus.lz_sup_i = 1'b0;
    wait_tick();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (bus.frame_tick !== (i == 0) || bus.ds_o !== ds_exp(i, 4'hF) ||
            bus.seg_o !== se[i/4] || bus.dp_o !== 1'b1) begin
          bad++;
          $display("FAIL scan: frame %0d cycle %0d tick=%b ds=%b seg=%h dp=%b, required %b %b %h 1",
                   f, i, bus.frame_tick, bus.ds_o, bus.seg_o, bus.dp_o, (i == 0), ds_exp(i, 4'hF), se[i/4]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_hex_dp();
    logic [6:0] se [4];
    se = '{~7'h39, ~7'h5E, ~7'h79, ~7'h71};   // C d E F
    bus.digits_i = 16'hFEDC; bus.dp_i = 4'b0101;
    wait_tick();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.ds_o !== ds_exp(i, 4'hF) || bus.seg_o !== se[i/4] || bus.dp_o !== ((i/4) % 2 == 1)) begin
        bad++;
        $display("FAIL hex_dp: cycle %0d ds=%b seg=%h dp=%b, required %b %h %b",
                 i, bus.ds_o, bus.seg_o, bus.dp_o, ds_exp(i, 4'hF), se[i/4], ((i/4) % 2 == 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable();
    bus.en_i = 4'b1010;
    wait_tick();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.ds_o !== ds_exp(i, 4'b1010) || bus.frame_tick !== (i == 0)) begin
        bad++;
        $display("FAIL enable: cycle %0d ds=%b tick=%b, required %b %b",
                 i, bus.ds_o, bus.frame_tick, ds_exp(i, 4'b1010), (i == 0));
      end
      @(negedge clk);
    end
    total++;
    if (bus.frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL enable_period: tick=%b at cycle 16, required 1", bus.frame_tick);
    end
  endtask

  task automatic test_lz();
    logic [6:0] se [4];
    bus.en_i = 4'hF; bus.dp_i = 4'h0; bus.lz_sup_i = 1'b1;
    bus.digits_i = 16'h0070;
    se = '{7'h40, 7'h78, 7'h7F, 7'h7F};   // '0', '7', blank, blank
    wait_tick();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.seg_o !== se[i/4] || bus.ds_o !== ds_exp(i, 4'hF)) begin
        bad++;
        $display("FAIL lz_0070: cycle %0d seg=%h ds=%b, required %h %b", i, bus.seg_o, bus.ds_o, se[i/4], ds_exp(i, 4'hF));
      end
      @(negedge clk);
    end
    bus.digits_i = 16'h0000;
    se = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    wait_tick();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.seg_o !== se[i/4]) begin
        bad++;
        $display("FAIL lz_0000: cycle %0d seg=%h, required %h", i, bus.seg_o, se[i/4]);
      end
      @(negedge clk);
    end
    bus.lz_sup_i = 1'b0;
  endtask

  task automatic test_tear_reset();
    bus.digits_i = 16'h1111; bus.en_i = 4'hF;
    wait_tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 6) bus.digits_i = 16'h2222;   // mid-frame change
      total++;
      if (bus.seg_o !== 7'h79) begin
        bad++;
        $display("FAIL tear_old: cycle %0d seg=%h, required 79", i, bus.seg_o);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.frame_tick !== (i == 0) || bus.seg_o !== 7'h24) begin
        bad++;
        $display("FAIL tear_new: cycle %0d tick=%b seg=%h, required %b 24", i, bus.frame_tick, bus.seg_o, (i == 0));
      end
      @(negedge clk);
    end
    repeat (8) @(negedge clk);            // now in slot 2
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ds_o !== 4'b1111 || bus.seg_o !== 7'h7F || bus.dp_o !== 1'b1 || bus.frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset: ds=%b seg=%h dp=%b tick=%b, required 1111 7f 1 0",
               bus.ds_o, bus.seg_o, bus.dp_o, bus.frame_tick);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.frame_tick !== (i == 0) || bus.ds_o !== 4'b1111) begin
        bad++;
        $display("FAIL reset_restart: cycle %0d tick=%b ds=%b, required %b 1111", i, bus.frame_tick, bus.ds_o, (i == 0));
      end
      @(negedge clk);
    end
    total++;
    if (bus.frame_tick !== 1'b1 || bus.ds_o !== 4'b1111 || bus.seg_o !== 7'h24) begin
      bad++;
      $display("FAIL reset_next_frame: tick=%b ds=%b seg=%h, required 1 1111 24", bus.frame_tick, bus.ds_o, bus.seg_o);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex_dp();
    test_enable();
    test_lz();
    test_tear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
